jtpang_rom_arb: RTL

//  Shares one 32-bit graphics ROM/SDRAM read port between the object line renderer (req 0) and
//  the scroll tile fetcher (req 1). Converts each requester's cs/addr/ok handshake into serialised

---
 rtl/jtpang_rom_arb.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/jtpang_rom_arb.sv
// Two-requester arbiter for a shared 32-bit graphics ROM read port.
// Requester 0 is the object line renderer, requester 1 the scroll tile fetcher.
// Each requester keeps the last word it read together with its address, so a
// repeated address is answered locally and issues no new downstream read.
module jtpang_rom_arb #(
  parameter int unsigned      AW0     = 17,
  parameter int unsigned      AW1     = 17,
  parameter int unsigned      OUTAW   = 18,
  parameter logic [OUTAW-1:0] OFFSET0 = OUTAW'(18'h0),
  parameter logic [OUTAW-1:0] OFFSET1 = OUTAW'(18'h20000),
  parameter bit               FIXPRIO = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  // requester 0
  input  logic [AW0-1:0]   addr0,
  input  logic             cs0,
  output logic             ok0,
  output logic [31:0]      data0,
  // requester 1
  input  logic [AW1-1:0]   addr1,
  input  logic             cs1,
  output logic             ok1,
  output logic [31:0]      data1,
  // downstream SDRAM slot
  output logic [OUTAW-1:0] rom_addr,
  output logic             rom_cs,
  input  logic [31:0]      rom_data,
  input  logic             rom_ok
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BUSY0 = 2'd1;
  localparam logic [1:0] BUSY1 = 2'd2;
  localparam logic [1:0] GAP   = 2'd3;

  logic [1:0]       state,    state_nx;
  logic             mask,     mask_nx;
  logic             last,     last_nx;
  logic [OUTAW-1:0] rom_addr_nx;
  logic             rom_cs_nx;
  logic [31:0]      data0_nx, data1_nx;
  logic [AW0-1:0]   haddr0,   haddr0_nx;
  logic [AW1-1:0]   haddr1,   haddr1_nx;
  logic             valid0,   valid0_nx;
  logic             valid1,   valid1_nx;

  logic             pend0, pend1, pick1;
  logic [OUTAW-1:0] base0, base1;

  // Local hit: the held word belongs to the address currently presented.
  assign ok0 = cs0 & valid0 & (addr0 == haddr0);
  assign ok1 = cs1 & valid1 & (addr1 == haddr1);

  // A requester being served is not pending again until its read lands.
  assign pend0 = cs0 & ~ok0 & (state != BUSY0);
  assign pend1 = cs1 & ~ok1 & (state != BUSY1);

  // Tie break: fixed priority to req 0, or whoever was not served last.
  assign pick1 = pend1 & (~pend0 | (~FIXPRIO & ~last));

  // Downstream addresses wrap modulo 2^OUTAW.
  assign base0 = OUTAW'(addr0) + OFFSET0;
  assign base1 = OUTAW'(addr1) + OFFSET1;

  // Next-state and register-input logic for the arbiter.
  always_comb begin
    state_nx    = state;
    mask_nx     = mask;
    last_nx     = last;
    rom_addr_nx = rom_addr;
    rom_cs_nx   = rom_cs;
    data0_nx    = data0;
    data1_nx    = data1;
    haddr0_nx   = haddr0;
    haddr1_nx   = haddr1;
    valid0_nx   = valid0;
    valid1_nx   = valid1;

    case (state)
      IDLE: begin
        if (pend0 | pend1) begin
          rom_cs_nx = 1'b1;
          mask_nx   = 1'b1;
          if (pick1) begin
            state_nx    = BUSY1;
            rom_addr_nx = base1;
            haddr1_nx   = addr1;
            valid1_nx   = 1'b0;
          end else begin
            state_nx    = BUSY0;
            rom_addr_nx = base0;
            haddr0_nx   = addr0;
            valid0_nx   = 1'b0;
          end
        end
      end
      BUSY0: begin
        // rom_ok may still belong to the previous address on the first cycle
        if (mask) begin
          mask_nx = 1'b0;
        end else if (rom_ok) begin
          data0_nx  = rom_data;
          valid0_nx = 1'b1;
          rom_cs_nx = 1'b0;
          last_nx   = 1'b0;
          state_nx  = GAP;
        end
      end
      BUSY1: begin
        if (mask) begin
          mask_nx = 1'b0;
        end else if (rom_ok) begin
          data1_nx  = rom_data;
          valid1_nx = 1'b1;
          rom_cs_nx = 1'b0;
          last_nx   = 1'b1;
          state_nx  = GAP;
        end
      end
      GAP: begin
        // lets the slot observe rom_cs low before the next read
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // State and data registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      mask     <= 1'b0;
      last     <= 1'b1;
      rom_addr <= '0;
      rom_cs   <= 1'b0;
      data0    <= '0;
      data1    <= '0;
      haddr0   <= '0;
      haddr1   <= '0;
      valid0   <= 1'b0;
      valid1   <= 1'b0;
    end else begin
      state    <= state_nx;
      mask     <= mask_nx;
      last     <= last_nx;
      rom_addr <= rom_addr_nx;
      rom_cs   <= rom_cs_nx;
      data0    <= data0_nx;
      data1    <= data1_nx;
      haddr0   <= haddr0_nx;
      haddr1   <= haddr1_nx;
      valid0   <= valid0_nx;
      valid1   <= valid1_nx;
    end
  end

endmodule
